// File: rtl/ifm_serial_loader_pkg.sv
// Shared constants and types for the IFM serial loader.
package ifm_serial_loader_pkg;

    localparam int PIX_W = 4;
    localparam int N_PIX = 32;
    localparam int IFM_W = N_PIX * PIX_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_WAIT = 2'd3
    } load_state_t;

    // Index width for an N-entry frame; at least one bit so a
    // single-pixel frame still has a legal counter.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ifm_serial_loader_if.sv
// Pixel-stream and frame-bus signals between upstream, loader and the
// convolution stage.
interface ifm_serial_loader_if #(
    parameter int PIX_W = ifm_serial_loader_pkg::PIX_W,
    parameter int N_PIX = ifm_serial_loader_pkg::N_PIX
);
    logic                   in_valid;
    logic                   in_start;
    logic [PIX_W-1:0]       In_pixel;
    logic                   in_ready;
    logic                   conv_out_valid;
    logic                   out_valid;
    logic [N_PIX*PIX_W-1:0] Out_IFM;
    logic                   frame_err;

    modport master (
        output in_valid, in_start, In_pixel, conv_out_valid,
        input  in_ready, out_valid, Out_IFM, frame_err
    );

    modport slave (
        input  in_valid, in_start, In_pixel, conv_out_valid,
        output in_ready, out_valid, Out_IFM, frame_err
    );
endinterface

// File: rtl/ifm_load_ctrl.sv
// Frame sequencing FSM and pixel index counter for the IFM loader.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   IDLE    | waiting for a pixel flagged as frame start
//   LOAD    | storing pixels at the counter index until the frame fills
//   SEND    | one-cycle frame strobe to the convolution stage
//   WAIT    | input blocked until convolution reports its result
module ifm_load_ctrl #(
    parameter int N_PIX = ifm_serial_loader_pkg::N_PIX,
    parameter int CNT_W = ifm_serial_loader_pkg::idx_w(N_PIX)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_start,
    input  logic             conv_out_valid,
    output logic             in_ready,
    output logic             out_valid,
    output logic             frame_err,
    output logic             wr_en,
    output logic [CNT_W-1:0] wr_idx
);
    import ifm_serial_loader_pkg::*;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_PIX - 1);
    localparam bit               SINGLE   = (N_PIX == 1);

    load_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign accept = in_valid && in_ready;

    // A start pixel always lands in slot 0; otherwise only LOAD stores.
    assign wr_en  = accept && (in_start || (state == ST_LOAD));
    assign wr_idx = in_start ? '0 : cnt;

    // Sequencing FSM; in_ready is registered so it stays low through reset
    // and only rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (in_start) begin
                            if (SINGLE) begin
                                cnt       <= '0;
                                state     <= ST_SEND;
                                in_ready  <= 1'b0;
                                out_valid <= 1'b1;
                            end else begin
                                cnt   <= CNT_W'(1);
                                state <= ST_LOAD;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (in_start) begin
                            cnt       <= CNT_W'(1);
                            frame_err <= 1'b1;
                        end else if (cnt == LAST_IDX) begin
                            cnt       <= '0;
                            state     <= ST_SEND;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_SEND: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (conv_out_valid) begin
                        state    <= ST_IDLE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    cnt      <= '0;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ifm_serial_loader.sv
// Collects a serial pixel stream into a full IFM frame register and hands
// it to the convolution stage with a one-cycle strobe.
module ifm_serial_loader #(
    parameter int PIX_W = ifm_serial_loader_pkg::PIX_W,
    parameter int N_PIX = ifm_serial_loader_pkg::N_PIX
) (
    input  logic                clk,
    input  logic                rst_n,
    ifm_serial_loader_if.slave  bus
);
    import ifm_serial_loader_pkg::*;

    localparam int CNT_W = idx_w(N_PIX);

    logic             wr_en;
    logic [CNT_W-1:0] wr_idx;
    logic [PIX_W-1:0] frame_q [N_PIX];

    ifm_load_ctrl #(
        .N_PIX (N_PIX),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (bus.in_valid),
        .in_start       (bus.in_start),
        .conv_out_valid (bus.conv_out_valid),
        .in_ready       (bus.in_ready),
        .out_valid      (bus.out_valid),
        .frame_err      (bus.frame_err),
        .wr_en          (wr_en),
        .wr_idx         (wr_idx)
    );

    // Frame slots are written one at a time; a restart only rewrites slot 0
    // and the rest are replaced as the new frame fills.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_PIX; i++) begin
                frame_q[i] <= '0;
            end
        end else if (wr_en) begin
            frame_q[wr_idx] <= bus.In_pixel;
        end
    end

    // Slot k maps to bits k*PIX_W upward of the frame bus.
    for (genvar k = 0; k < N_PIX; k++) begin : g_pack
        assign bus.Out_IFM[k*PIX_W +: PIX_W] = frame_q[k];
    end

endmodule

// File: tb/tb_ifm_serial_loader.sv
// Directed bench for the IFM serial loader.
module tb_ifm_serial_loader;
    import ifm_serial_loader_pkg::*;

    localparam int FW = IFM_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ifm_serial_loader_if #(.PIX_W(PIX_W), .N_PIX(N_PIX)) bus ();

    ifm_serial_loader #(.PIX_W(PIX_W), .N_PIX(N_PIX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int ov_cnt = 0;
    int fe_cnt = 0;

    // Count strobes just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (bus.out_valid === 1'b1) ov_cnt++;
        if (bus.frame_err === 1'b1) fe_cnt++;
    end

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [PIX_W-1:0] p);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_start = s;
        bus.In_pixel = p;
    endtask

    function automatic logic [FW-1:0] ramp_frame();
        logic [FW-1:0] f;
        f = '0;
        for (int k = 0; k < N_PIX; k++) f[k*PIX_W +: PIX_W] = PIX_W'((k + 1) % 16);
        return f;
    endfunction

    function automatic logic [FW-1:0] down_frame();
        logic [FW-1:0] f;
        f = '0;
        for (int k = 0; k < N_PIX; k++) f[k*PIX_W +: PIX_W] = PIX_W'((47 - k) % 16);
        return f;
    endfunction

    function automatic logic [FW-1:0] fill_frame(input logic [PIX_W-1:0] v);
        logic [FW-1:0] f;
        f = '0;
        for (int k = 0; k < N_PIX; k++) f[k*PIX_W +: PIX_W] = v;
        return f;
    endfunction

    // Stream one frame, optionally with an idle cycle between pixels, and
    // check the strobe in the cycle after the last pixel.
    task automatic send_frame(input logic [FW-1:0] f, input bit gap, input string tag);
        int ov0;
        ov0 = ov_cnt;
        for (int k = 0; k < N_PIX; k++) begin
            drive(1'b1, (k == 0), f[k*PIX_W +: PIX_W]);
            if (gap && (k != N_PIX - 1)) drive(1'b0, 1'b0, '0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_start = 1'b0;
        chk({tag, "_ov"}, FW'(bus.out_valid), FW'(1));
        chk({tag, "_ifm"}, bus.Out_IFM, f);
        chk({tag, "_ovcnt"}, FW'(ov_cnt - ov0), FW'(1));
    endtask

    task automatic conv_ack(input string tag);
        @(negedge clk);
        chk({tag, "_wait_rdy"}, FW'(bus.in_ready), FW'(0));
        bus.conv_out_valid = 1'b1;
        @(negedge clk);
        bus.conv_out_valid = 1'b0;
        chk({tag, "_idle_rdy"}, FW'(bus.in_ready), FW'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe0;
        int ov0;
        logic [FW-1:0] f2;

        bus.in_valid       = 1'b0;
        bus.in_start       = 1'b0;
        bus.In_pixel       = '0;
        bus.conv_out_valid = 1'b0;
        f2 = down_frame();

        // Reset values
        #12;
        chk("rst_rdy", FW'(bus.in_ready), FW'(0));
        chk("rst_ov", FW'(bus.out_valid), FW'(0));
        chk("rst_ifm", bus.Out_IFM, '0);
        chk("rst_fe", FW'(bus.frame_err), FW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_rdy", FW'(bus.in_ready), FW'(1));

        // Non-start pixel in IDLE
        fe0 = fe_cnt;
        drive(1'b1, 1'b0, 4'hF);
        drive(1'b0, 1'b0, '0);
        chk("idle_err_fe", FW'(bus.frame_err), FW'(1));
        chk("idle_err_rdy", FW'(bus.in_ready), FW'(1));
        chk("idle_err_ifm", bus.Out_IFM, '0);
        @(negedge clk);
        chk("idle_err_fe_off", FW'(bus.frame_err), FW'(0));
        chk("idle_err_fecnt", FW'(fe_cnt - fe0), FW'(1));

        // Back-to-back frame
        send_frame(ramp_frame(), 1'b0, "b2b");
        conv_ack("b2b");

        // Frame with idle cycles between pixels
        send_frame(ramp_frame(), 1'b1, "gap");
        conv_ack("gap");

        // Second frame offered while waiting for convolution
        send_frame(f2, 1'b0, "f2");
        fe0 = fe_cnt;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lock_rdy", FW'(bus.in_ready), FW'(0));
            bus.in_valid = 1'b1;
            bus.in_start = 1'b1;
            bus.In_pixel = 4'hA;
        end
        @(negedge clk);
        chk("lock_ifm", bus.Out_IFM, f2);
        chk("lock_fecnt", FW'(fe_cnt - fe0), FW'(0));
        bus.in_valid = 1'b0;
        bus.in_start = 1'b0;
        bus.conv_out_valid = 1'b1;
        @(negedge clk);
        bus.conv_out_valid = 1'b0;
        chk("lock_rel_rdy", FW'(bus.in_ready), FW'(1));
        send_frame(ramp_frame(), 1'b0, "after_wait");
        conv_ack("after_wait");

        // Restart at pixel 10
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        drive(1'b1, 1'b1, 4'h5);
        for (int i = 1; i < 10; i++) drive(1'b1, 1'b0, 4'h5);
        drive(1'b1, 1'b1, 4'h3);
        for (int i = 1; i < N_PIX; i++) drive(1'b1, 1'b0, 4'h3);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_start = 1'b0;
        chk("rs_ov", FW'(bus.out_valid), FW'(1));
        chk("rs_ifm", bus.Out_IFM, fill_frame(4'h3));
        chk("rs_fecnt", FW'(fe_cnt - fe0), FW'(1));
        chk("rs_ovcnt", FW'(ov_cnt - ov0), FW'(1));
        conv_ack("rs");

        // Reset in the middle of a frame
        for (int k = 0; k < 20; k++) drive(1'b1, (k == 0), PIX_W'(k % 16));
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rdy", FW'(bus.in_ready), FW'(0));
        chk("mid_rst_ifm", bus.Out_IFM, '0);
        chk("mid_rst_ov", FW'(bus.out_valid), FW'(0));
        chk("mid_rst_fe", FW'(bus.frame_err), FW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_rdy", FW'(bus.in_ready), FW'(1));
        ov0 = ov_cnt;
        send_frame(f2, 1'b0, "post_rst");
        conv_ack("post_rst");
        repeat (3) @(negedge clk);
        chk("post_rst_ovcnt", FW'(ov_cnt - ov0), FW'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
